// File: rtl/nonsynth_axi_mem.sv
// AXI4 slave memory model with independent single-outstanding read and write engines.
// Optional macro AXI_MEM_RANGE_CHECK_EN: out-of-range beats are dropped/zeroed and answered with SLVERR.
module nonsynth_axi_mem #(
    parameter int axi_id_width_p   = 6,
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 32,
    parameter int axi_len_width_p  = 4,
    parameter int mem_els_p        = 2**16,
    parameter logic [axi_data_width_p-1:0] init_data_p = '0
) (
    input  logic                          aclk,
    input  logic                          aresetn,

    input  logic [axi_id_width_p-1:0]     axi_awid_i,
    input  logic [axi_addr_width_p-1:0]   axi_awaddr_i,
    input  logic [axi_len_width_p-1:0]    axi_awlen_i,
    input  logic [1:0]                    axi_awburst_i,
    input  logic                          axi_awvalid_i,
    output logic                          axi_awready_o,

    input  logic [axi_data_width_p-1:0]   axi_wdata_i,
    input  logic [axi_data_width_p/8-1:0] axi_wstrb_i,
    input  logic                          axi_wlast_i,
    input  logic                          axi_wvalid_i,
    output logic                          axi_wready_o,

    output logic [axi_id_width_p-1:0]     axi_bid_o,
    output logic [1:0]                    axi_bresp_o,
    output logic                          axi_bvalid_o,
    input  logic                          axi_bready_i,

    input  logic [axi_id_width_p-1:0]     axi_arid_i,
    input  logic [axi_addr_width_p-1:0]   axi_araddr_i,
    input  logic [axi_len_width_p-1:0]    axi_arlen_i,
    input  logic [1:0]                    axi_arburst_i,
    input  logic                          axi_arvalid_i,
    output logic                          axi_arready_o,

    output logic [axi_id_width_p-1:0]     axi_rid_o,
    output logic [axi_data_width_p-1:0]   axi_rdata_o,
    output logic [1:0]                    axi_rresp_o,
    output logic                          axi_rlast_o,
    output logic                          axi_rvalid_o,
    input  logic                          axi_rready_i
);

    localparam int strb_w = axi_data_width_p / 8;
    localparam int off_w  = $clog2(strb_w);
    localparam int idx_w  = $clog2(mem_els_p);
    localparam int word_w = axi_addr_width_p - off_w;
    localparam logic [1:0] resp_okay   = 2'b00;
    localparam logic [1:0] resp_slverr = 2'b10;

    typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_e;
    typedef enum logic       {RIDLE, RDATA}        rstate_e;

    // Contents are loaded once at time zero and are never touched by reset.
    logic [axi_data_width_p-1:0] mem [mem_els_p] = '{default: init_data_p};

    wstate_e                    w_state, w_state_next;
    logic [axi_id_width_p-1:0]  w_id;
    logic [word_w-1:0]          w_addr;
    logic [axi_len_width_p-1:0] w_len, w_cnt;
    logic [1:0]                 w_burst;
    logic                       w_err;

    rstate_e                    r_state, r_state_next;
    logic [axi_id_width_p-1:0]  r_id;
    logic [word_w-1:0]          r_addr;
    logic [axi_len_width_p-1:0] r_len, r_cnt;
    logic [1:0]                 r_burst;

    logic aw_hs, w_hs, ar_hs, r_hs;
    logic w_oor, r_oor;

    // Word address of the following beat; WRAP stays inside a (len+1)-word aligned window.
    function automatic logic [word_w-1:0] next_addr(input logic [word_w-1:0] addr,
                                                    input logic [1:0] burst,
                                                    input logic [axi_len_width_p-1:0] len);
        logic [word_w-1:0] mask;
        mask = word_w'(len);
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) | ((addr + word_w'(1)) & mask);
            default: next_addr = addr + word_w'(1);
        endcase
    endfunction

`ifdef AXI_MEM_RANGE_CHECK_EN
    assign w_oor = (w_addr >> idx_w) != '0;
    assign r_oor = (r_addr >> idx_w) != '0;
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{axi_wlast_i, w_addr >> idx_w, r_addr >> idx_w};

    assign aw_hs = axi_awvalid_i & axi_awready_o;
    assign w_hs  = axi_wvalid_i  & axi_wready_o;
    assign ar_hs = axi_arvalid_i & axi_arready_o;
    assign r_hs  = axi_rvalid_o  & axi_rready_i;

    always_comb begin
        w_state_next  = w_state;
        axi_awready_o = 1'b0;
        axi_wready_o  = 1'b0;
        axi_bvalid_o  = 1'b0;
        case (w_state)
            WIDLE: begin
                axi_awready_o = aresetn;
                if (axi_awvalid_i && aresetn) w_state_next = WDATA;
            end
            WDATA: begin
                axi_wready_o = 1'b1;
                if (axi_wvalid_i && (w_cnt == w_len)) w_state_next = WRESP;
            end
            WRESP: begin
                axi_bvalid_o = 1'b1;
                if (axi_bready_i) w_state_next = WIDLE;
            end
            default: w_state_next = WIDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= WIDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_state_next;
            if (aw_hs) begin
                w_id    <= axi_awid_i;
                w_addr  <= word_w'(axi_awaddr_i >> off_w);
                w_len   <= axi_awlen_i;
                w_burst <= axi_awburst_i;
                w_cnt   <= '0;
                w_err   <= 1'b0;
            end else if (w_hs) begin
                w_cnt  <= w_cnt + axi_len_width_p'(1);
                w_addr <= next_addr(w_addr, w_burst, w_len);
                if (w_oor) w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && !w_oor) begin
            for (int b = 0; b < strb_w; b++) begin
                if (axi_wstrb_i[b]) mem[w_addr[idx_w-1:0]][b*8 +: 8] <= axi_wdata_i[b*8 +: 8];
            end
        end
    end

    assign axi_bid_o   = w_id;
    assign axi_bresp_o = (w_state == WRESP && w_err) ? resp_slverr : resp_okay;

    always_comb begin
        r_state_next  = r_state;
        axi_arready_o = 1'b0;
        axi_rvalid_o  = 1'b0;
        case (r_state)
            RIDLE: begin
                axi_arready_o = aresetn;
                if (axi_arvalid_i && aresetn) r_state_next = RDATA;
            end
            RDATA: begin
                axi_rvalid_o = 1'b1;
                if (axi_rready_i && (r_cnt == r_len)) r_state_next = RIDLE;
            end
            default: r_state_next = RIDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= RIDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= r_state_next;
            if (ar_hs) begin
                r_id    <= axi_arid_i;
                r_addr  <= word_w'(axi_araddr_i >> off_w);
                r_len   <= axi_arlen_i;
                r_burst <= axi_arburst_i;
                r_cnt   <= '0;
            end else if (r_hs) begin
                r_cnt  <= r_cnt + axi_len_width_p'(1);
                r_addr <= next_addr(r_addr, r_burst, r_len);
            end
        end
    end

    // Combinational read: a write landing on the same edge is seen only from the next cycle.
    assign axi_rid_o   = r_id;
    assign axi_rdata_o = (r_state == RDATA && !r_oor) ? mem[r_addr[idx_w-1:0]] : '0;
    assign axi_rresp_o = (r_state == RDATA && r_oor) ? resp_slverr : resp_okay;
    assign axi_rlast_o = (r_state == RDATA) && (r_cnt == r_len);

endmodule

// File: tb/tb_nonsynth_axi_mem.sv
// Directed bench for nonsynth_axi_mem: write/read bursts, strobes, backpressure, wrap, async reset.
module tb_nonsynth_axi_mem;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [5:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awlen, arlen, wstrb;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int n_checks = 0;
    int n_pass   = 0;

    nonsynth_axi_mem dut (
        .aclk(aclk), .aresetn(aresetn),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awburst_i(awburst),
        .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arburst_i(arburst),
        .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
        .axi_rvalid_o(rvalid), .axi_rready_i(rready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_aw(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        while (!awready && n < 20) begin @(posedge aclk); #1; n++; end
        check("awready", 32'(awready), 1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        while (!wready && n < 20) begin @(posedge aclk); #1; n++; end
        check("wready", 32'(wready), 1);
        @(posedge aclk); #1;
        wvalid = 1'b0;
    endtask

    task automatic do_b(input logic [5:0] id);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 20) begin @(posedge aclk); #1; n++; end
        check("bvalid", 32'(bvalid), 1);
        check("bid", 32'(bid), 32'(id));
        check("bresp", 32'(bresp), 0);
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic do_ar(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        while (!arready && n < 20) begin @(posedge aclk); #1; n++; end
        check("arready", 32'(arready), 1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        check("r_first_cycle", 32'(rvalid), 1);
    endtask

    task automatic read_beat(input string tag, input logic [31:0] data, input logic last,
                             input logic [5:0] id, input logic [1:0] resp);
        int n = 0;
        rready = 1'b1;
        while (!rvalid && n < 20) begin @(posedge aclk); #1; n++; end
        check({tag, "_rvalid"}, 32'(rvalid), 1);
        check({tag, "_rdata"}, rdata, data);
        check({tag, "_rlast"}, 32'(rlast), 32'(last));
        check({tag, "_rid"}, 32'(rid), 32'(id));
        check({tag, "_rresp"}, 32'(rresp), 32'(resp));
        @(posedge aclk); #1;
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_awready", 32'(awready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rlast", 32'(rlast), 0);
        check("rst_ids", 32'({bid, rid}), 0);
        check("rst_resp", 32'({bresp, rresp}), 0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("post_rst_awready", 32'(awready), 1);
        check("post_rst_arready", 32'(arready), 1);

        // Single beat write/read
        do_aw(6'd5, 32'h100, 4'd0, 2'b01);
        do_w(32'hDEADBEEF, 4'hF, 1'b1);
        do_b(6'd5);
        do_ar(6'd5, 32'h100, 4'd0, 2'b01);
        read_beat("single", 32'hDEADBEEF, 1'b1, 6'd5, 2'b00);

        // INCR burst, then INCR and FIXED reads
        do_aw(6'd3, 32'h200, 4'd3, 2'b01);
        for (int i = 1; i <= 4; i++) do_w(32'(i), 4'hF, i == 4);
        do_b(6'd3);
        do_ar(6'd4, 32'h200, 4'd3, 2'b01);
        for (int i = 1; i <= 4; i++) read_beat("incr", 32'(i), i == 4, 6'd4, 2'b00);
        do_ar(6'd6, 32'h200, 4'd3, 2'b00);
        for (int i = 1; i <= 4; i++) read_beat("fixed", 32'd1, i == 4, 6'd6, 2'b00);

        // Byte strobes
        do_aw(6'd1, 32'h300, 4'd0, 2'b01);
        do_w(32'h11223344, 4'hF, 1'b1);
        do_b(6'd1);
        do_aw(6'd1, 32'h300, 4'd0, 2'b01);
        do_w(32'hAABBCCDD, 4'b0101, 1'b1);
        do_b(6'd1);
        do_ar(6'd1, 32'h300, 4'd0, 2'b01);
        read_beat("strb", 32'h11BB33DD, 1'b1, 6'd1, 2'b00);

        // Write response backpressure with a pending AW
        do_aw(6'd7, 32'h400, 4'd1, 2'b01);
        do_w(32'hA0, 4'hF, 1'b0);
        do_w(32'hA1, 4'hF, 1'b1);
        awid = 6'd8; awaddr = 32'h500; awlen = 4'd0; awburst = 2'b01; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid_held", 32'(bvalid), 1);
            check("bp_awready_low", 32'(awready), 0);
            @(posedge aclk); #1;
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        check("bp_bvalid_done", 32'(bvalid), 0);
        check("bp_awready_after_b", 32'(awready), 1);
        awvalid = 1'b0;

        // Read backpressure: rready 1,0,0,1
        do_ar(6'd7, 32'h400, 4'd1, 2'b01);
        rready = 1'b1;
        check("rbp_beat0", rdata, 32'hA0);
        check("rbp_last0", 32'(rlast), 0);
        @(posedge aclk); #1;
        rready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rbp_stall_valid", 32'(rvalid), 1);
            check("rbp_stall_data", rdata, 32'hA1);
            check("rbp_stall_last", 32'(rlast), 1);
            @(posedge aclk); #1;
        end
        rready = 1'b1;
        check("rbp_beat1", rdata, 32'hA1);
        @(posedge aclk); #1;
        rready = 1'b0;
        check("rbp_done", 32'(rvalid), 0);

        // WRAP burst over the 16-byte window at 0x100
        do_aw(6'd2, 32'h100, 4'd3, 2'b01);
        for (int i = 0; i < 4; i++) do_w(32'h10 + 32'(i), 4'hF, i == 3);
        do_b(6'd2);
        do_ar(6'd2, 32'h108, 4'd3, 2'b10);
        read_beat("wrap0", 32'h12, 1'b0, 6'd2, 2'b00);
        read_beat("wrap1", 32'h13, 1'b0, 6'd2, 2'b00);
        read_beat("wrap2", 32'h10, 1'b0, 6'd2, 2'b00);
        read_beat("wrap3", 32'h11, 1'b1, 6'd2, 2'b00);

        // Unwritten location holds the initial value
        do_ar(6'd1, 32'h4000, 4'd0, 2'b01);
        read_beat("init", 32'h0, 1'b1, 6'd1, 2'b00);

        // Asynchronous reset in the middle of a read burst
        do_ar(6'd9, 32'h200, 4'd3, 2'b01);
        read_beat("pre_rst0", 32'd1, 1'b0, 6'd9, 2'b00);
        read_beat("pre_rst1", 32'd2, 1'b0, 6'd9, 2'b00);
        aresetn = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(rvalid), 0);
        check("mid_rst_rlast", 32'(rlast), 0);
        check("mid_rst_arready", 32'(arready), 0);
        check("mid_rst_rid", 32'(rid), 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("after_rst_arready", 32'(arready), 1);
        check("after_rst_rvalid", 32'(rvalid), 0);
        do_ar(6'd9, 32'h204, 4'd0, 2'b01);
        read_beat("after_rst", 32'd2, 1'b1, 6'd9, 2'b00);

`ifdef AXI_MEM_RANGE_CHECK_EN
        do_ar(6'd3, 32'h0004_0000, 4'd0, 2'b01);
        read_beat("oor", 32'h0, 1'b1, 6'd3, 2'b10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nonsynth_axi_mem.md
Name: nonsynth_axi_mem

Overview:
- Non-synthesizable AXI4 slave memory model for cosimulation; backs the accelerator's M00 AXI master port with a word-addressed array.
- Independent read and write engines, each handling one burst at a time: single outstanding write and single outstanding read.
- Memory contents persist across reset.

Parameters:
- axi_id_width_p, 6, width of AWID/BID/ARID/RID.
- axi_addr_width_p, 32, byte-address width.
- axi_data_width_p, 32, data beat width; power of two, at least 8.
- axi_len_width_p, 4, width of AWLEN/ARLEN; beats per burst = len+1.
- mem_els_p, 2**16, number of data-width words; power of two.
- init_data_p, 0, value loaded into every word at time zero.

Ports:
- aclk in 1: single clock, all logic on the rising edge.
- aresetn in 1: asynchronous active-low reset.
- axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awburst_i in id/addr/len/2; axi_awvalid_i in 1; axi_awready_o out 1.
- axi_wdata_i in data; axi_wstrb_i in data/8; axi_wlast_i in 1; axi_wvalid_i in 1; axi_wready_o out 1.
- axi_bid_o out id; axi_bresp_o out 2; axi_bvalid_o out 1; axi_bready_i in 1.
- axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arburst_i in id/addr/len/2; axi_arvalid_i in 1; axi_arready_o out 1.
- axi_rid_o out id; axi_rdata_o out data; axi_rresp_o out 2; axi_rlast_o out 1; axi_rvalid_o out 1; axi_rready_i in 1.

Behaviour:
- Word index = addr >> log2(data/8), truncated to log2(mem_els_p) bits, so addresses wrap modulo memory size. Low byte-offset bits are ignored.
- Memory is set to init_data_p by an initial block. Reset does not touch memory.
- Reset (aresetn=0, asynchronous) forces both FSMs to idle and clears the beat counters and stored IDs/len/burst.
- During reset, all ready and valid outputs are 0. bresp/rresp/rlast/rid/bid are 0.
- Write FSM WIDLE -> WDATA -> WRESP -> WIDLE:
  - WIDLE: awready=1. An AW handshake latches id, index, len and burst, clears the beat count, and moves to WDATA.
  - WDATA: wready=1. Each W handshake writes the bytes whose wstrb bit is set. Writes become visible to reads the following cycle. Count increments.
  - On the beat where count==len, move to WRESP. wlast is not used for termination.
  - WRESP: bvalid=1, bid=latched id, bresp=OKAY (00). On bready, return to WIDLE. The next AW is accepted no earlier than the cycle after the B handshake.
- Read FSM RIDLE -> RDATA -> RIDLE:
  - RIDLE: arready=1. An AR handshake latches id, index, len and burst, and moves to RDATA.
  - RDATA: rvalid=1, rdata=mem[current index] read combinationally, rid=latched id, rresp=OKAY, rlast=(count==len).
  - On each rready, advance; after the last beat return to RIDLE. First data appears the cycle after the AR handshake.
- Address progression per beat:
  - FIXED (00): index unchanged.
  - INCR (01), and reserved (11): index+1.
  - WRAP (10): increment within an aligned window of (len+1) words; len+1 must be 2/4/8/16.
- Read and write engines are fully independent and may both be active in the same cycle.
- Same-cycle write and read of the same word: the read returns the pre-write data.
- len=0 gives a single-beat burst (rlast=1 on the first beat).
- Holding valid while the slave is not ready never loses data.
- Outputs remain stable while valid is high and ready is low.

Optional Feature:
- Macro AXI_MEM_RANGE_CHECK_EN.
- Defined:
  - A beat is out of range when its word address (addr >> log2(data/8), before truncation) is ≥ mem_els_p.
  - An out-of-range write beat is dropped. An out-of-range read beat returns 0 with rresp=SLVERR (10).
  - bresp=SLVERR if any beat of the burst was out of range.
- Undefined: addresses wrap modulo mem_els_p and all responses are OKAY.

Test Plan:
- Single write then read (data 32b, len=0): AW addr 0x100 id 5, W 0xDEADBEEF strb F -> bvalid with bid=5, bresp=0. AR 0x100 -> rdata 0xDEADBEEF, rlast=1, rid=5.
- INCR burst len=3 at 0x200 writing 1,2,3,4, then read back -> 4 beats 1,2,3,4 with rlast only on beat 4. FIXED read of the same burst returns 1 on every beat.
- Byte strobes: write 0x11223344 strb F, then 0xAABBCCDD strb 0101 -> read 0x11BB33DD.
- Backpressure: rready toggles 1,0,0,1 and bready held 0 for 5 cycles -> rdata/rlast stable while stalled, no beat lost, awready stays 0 until the B handshake.
- WRAP len=3 starting at 0x108 -> beat indices 2,3,0,1 within the 16-byte window. Read of unwritten 0x4000 returns init_data_p.
- Async reset asserted mid-burst (after 2 of 4 read beats) -> rvalid drops immediately, FSM returns to idle, and earlier-written data is still readable after reset. With AXI_MEM_RANGE_CHECK_EN, a read at word mem_els_p gives rresp=10, rdata=0.
